// File: rtl/audio_tone_mixer_pkg.sv
// Shared constants and helpers for the audio tone mixer: CTRL field positions, register selects, mixer width.
package audio_tone_pkg;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_DONE    = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_VOL_LSB = 8;
    localparam int CTRL_DUR_LSB = 16;
    localparam int DUR_W        = 16;

    typedef enum logic {
        SEL_PERIOD = 1'b0,
        SEL_CTRL   = 1'b1
    } sel_e;

    // Wide enough to hold NUM_CH full-volume contributions without overflow.
    function automatic int sum_width(input int vol_w, input int num_ch);
        return vol_w + $clog2(num_ch) + 1;
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_tone_mixer_if.sv
// Avalon-MM slave bus bundle for the audio tone mixer register file.
interface audio_tone_mixer_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata
    );
endinterface

// File: rtl/audio_tone_mixer_tone_channel.sv
// One tone channel: PERIOD/CTRL registers, half-period divider, phase and duration countdown.
// With AUDIO_TONE_IRQ_EN defined, adds the sticky DONE flag and IE enable.
module tone_channel
    import audio_tone_pkg::*;
#(
    parameter int PERIOD_W = 20,
    parameter int VOL_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_period_i,
    input  logic               wr_ctrl_i,
    input  logic [3:0]         byteenable_i,
    input  logic [31:0]        writedata_i,
    input  logic               tick_i,
    output logic [31:0]        period_rd_o,
    output logic [31:0]        ctrl_rd_o,
    output logic               phase_o,
    output logic [VOL_W-1:0]   vol_o
`ifdef AUDIO_TONE_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic                en_q, en_d;
    logic [VOL_W-1:0]    vol_q, vol_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                expire;
    logic                restart;
    logic [31:0]         ctrl_base;
    logic [31:0]         ctrl_new;
`ifdef AUDIO_TONE_IRQ_EN
    logic                done_q, done_d;
    logic                ie_q, ie_d;
`endif

    always_comb begin
        ctrl_rd_o = '0;
        ctrl_rd_o[CTRL_EN] = en_q;
        ctrl_rd_o[CTRL_VOL_LSB +: VOL_W] = vol_q;
        ctrl_rd_o[CTRL_DUR_LSB +: DUR_W] = dur_q;
`ifdef AUDIO_TONE_IRQ_EN
        ctrl_rd_o[CTRL_DONE] = done_q;
        ctrl_rd_o[CTRL_IE]   = ie_q;
`endif
    end

    assign period_rd_o = 32'(period_q);
    assign phase_o     = phase_q;
    assign vol_o       = vol_q;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        period_d  = period_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        en_d      = en_q;
        vol_d     = vol_q;
        dur_d     = dur_q;
        expire    = 1'b0;
        ctrl_base = '0;
        ctrl_new  = '0;
`ifdef AUDIO_TONE_IRQ_EN
        done_d    = done_q;
        ie_d      = ie_q;
`endif

        if (tick_i && en_q && dur_q != '0) begin
            dur_d = dur_q - 1'b1;
            if (dur_q == DUR_W'(1)) begin
                en_d   = 1'b0;
                expire = 1'b1;
            end
        end
`ifdef AUDIO_TONE_IRQ_EN
        if (expire) done_d = 1'b1;
`endif

        if (wr_period_i) begin
            period_d = PERIOD_W'(merge_be(32'(period_q), writedata_i, byteenable_i));
        end

        // A CTRL write lands on top of the post-expiry state, so written fields win.
        if (wr_ctrl_i) begin
            ctrl_base = ctrl_rd_o;
            ctrl_base[CTRL_EN] = en_d;
            ctrl_base[CTRL_DUR_LSB +: DUR_W] = dur_d;
            ctrl_new = merge_be(ctrl_base, writedata_i, byteenable_i);
            en_d  = ctrl_new[CTRL_EN];
            vol_d = ctrl_new[CTRL_VOL_LSB +: VOL_W];
            dur_d = ctrl_new[CTRL_DUR_LSB +: DUR_W];
`ifdef AUDIO_TONE_IRQ_EN
            ie_d = ctrl_new[CTRL_IE];
            if (byteenable_i[0] && writedata_i[CTRL_DONE] && !expire) done_d = 1'b0;
`endif
        end

        restart = wr_period_i || (wr_ctrl_i && en_d && !en_q);
        if (restart || !en_q || period_q < PERIOD_W'(2)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q - PERIOD_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            en_q     <= 1'b0;
            vol_q    <= '0;
            dur_q    <= '0;
`ifdef AUDIO_TONE_IRQ_EN
            done_q   <= 1'b0;
            ie_q     <= 1'b0;
`endif
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            en_q     <= en_d;
            vol_q    <= vol_d;
            dur_q    <= dur_d;
`ifdef AUDIO_TONE_IRQ_EN
            done_q   <= done_d;
            ie_q     <= ie_d;
`endif
        end
    end

`ifdef AUDIO_TONE_IRQ_EN
    assign irq_o = done_q & ie_q;
`endif

endmodule

// File: rtl/audio_tone_mixer.sv
// NUM_CH-channel square-wave tone mixer behind an Avalon-MM slave, PWM output on speaker.
// Define AUDIO_TONE_IRQ_EN to add per-channel DONE/IE bits and the irq output.
module audio_tone_mixer
    import audio_tone_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 20,
    parameter int VOL_W    = 4,
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    audio_tone_mixer_if.slave bus,
    output logic              speaker
`ifdef AUDIO_TONE_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int ADDR_W = $clog2(NUM_CH) + 1;
    localparam int SUM_W  = sum_width(VOL_W, NUM_CH);
    localparam int TICK_W = $clog2(TICK_DIV);

    logic [ADDR_W-1:0] ch_idx;
    sel_e              sel;
    logic              in_range;
    logic              wr_en;
    logic              rd_en;
    logic              tick;

    logic [NUM_CH-1:0] wr_period;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] phase;
    logic [VOL_W-1:0]  vol       [NUM_CH];
    logic [31:0]       period_rd [NUM_CH];
    logic [31:0]       ctrl_rd   [NUM_CH];
`ifdef AUDIO_TONE_IRQ_EN
    logic [NUM_CH-1:0] ch_irq;
    logic              irq_q;
`endif

    logic [TICK_W-1:0] tick_cnt_q;
    logic [SUM_W-1:0]  sum_d;
    logic [SUM_W-1:0]  pwm_cnt_q;
    logic [SUM_W-1:0]  duty_q;
    logic              speaker_q;
    logic [31:0]       rd_data_d;
    logic [31:0]       readdata_q;

    assign ch_idx   = ADDR_W'(bus.address >> 1);
    assign sel      = sel_e'(bus.address[0]);
    assign in_range = ch_idx < ADDR_W'(NUM_CH);
    assign wr_en    = bus.chipselect & bus.write & in_range;
    assign rd_en    = bus.chipselect & bus.read;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign wr_period[c] = wr_en && ch_idx == ADDR_W'(c) && sel == SEL_PERIOD;
        assign wr_ctrl[c]   = wr_en && ch_idx == ADDR_W'(c) && sel == SEL_CTRL;

        tone_channel #(
            .PERIOD_W (PERIOD_W),
            .VOL_W    (VOL_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .wr_period_i  (wr_period[c]),
            .wr_ctrl_i    (wr_ctrl[c]),
            .byteenable_i (bus.byteenable),
            .writedata_i  (bus.writedata),
            .tick_i       (tick),
            .period_rd_o  (period_rd[c]),
            .ctrl_rd_o    (ctrl_rd[c]),
            .phase_o      (phase[c]),
            .vol_o        (vol[c])
`ifdef AUDIO_TONE_IRQ_EN
            ,
            .irq_o        (ch_irq[c])
`endif
        );
    end

    assign tick = tick_cnt_q == TICK_W'(TICK_DIV - 1);

    // Out-of-range channels match no entry and read back as zero.
    always_comb begin
        rd_data_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == ADDR_W'(c)) begin
                rd_data_d = (sel == SEL_CTRL) ? ctrl_rd[c] : period_rd[c];
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_d = sum_d + (phase[c] ? SUM_W'(vol[c]) : '0);
        end
    end

    // Duty only moves at the all-ones wrap, so a PWM period never sees two duty values.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            speaker_q  <= 1'b0;
            readdata_q <= '0;
`ifdef AUDIO_TONE_IRQ_EN
            irq_q      <= 1'b0;
`endif
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            if (&pwm_cnt_q) duty_q <= sum_d;
            speaker_q  <= pwm_cnt_q < duty_q;
            if (rd_en) readdata_q <= rd_data_d;
`ifdef AUDIO_TONE_IRQ_EN
            irq_q      <= |ch_irq;
`endif
        end
    end

    assign bus.readdata = readdata_q;
    assign speaker      = speaker_q;
`ifdef AUDIO_TONE_IRQ_EN
    assign irq          = irq_q;
`endif

endmodule
